adma_transfer: RTL and testbench

ADMA_TRANSFER -- requirements
Module: adma_transfer

---
 rtl/adma_pkg.sv | 40 ++++
 rtl/adma_beat_counter.sv | 32 +++
 rtl/adma_transfer.sv | 136 +++++++++++++
 tb/tb_adma_transfer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_pkg.sv
// Shared ADMA2 descriptor layout, action codes and controller state encoding.
package adma_pkg;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DESC,
        S_DECODE,
        S_XFER,
        S_NEXT,
        S_FINISH,
        S_ERR
    } state_e;

    localparam int unsigned DESC_VALID_BIT = 0;
    localparam int unsigned DESC_END_BIT   = 1;
    localparam int unsigned DESC_INT_BIT   = 2;
    localparam int unsigned DESC_ACT_LSB   = 4;
    localparam int unsigned DESC_LEN_LSB   = 16;
    localparam int unsigned DESC_ADDR_LSB  = 32;

    localparam int unsigned ZERO_LEN_BYTES = 65536;
    localparam logic [63:0] DESC_STRIDE    = 64'd8;

    // A zero length field encodes a full 64 KiB transfer.
    function automatic logic [16:0] beats_for_len(input logic [15:0] len,
                                                  input int unsigned beat_bytes);
        logic [17:0] bytes;
        bytes = (len == 16'd0) ? 18'(ZERO_LEN_BYTES) : {2'b00, len};
        return 17'((bytes + 18'(beat_bytes - 1)) / 18'(beat_bytes));
    endfunction

endpackage

// File: rtl/adma_beat_counter.sv
// Data-phase beat counter: tracks remaining beats and advances the beat address.
module adma_beat_counter #(
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_addr,
    input  logic [16:0] load_beats,
    input  logic        step,
    output logic [63:0] addr,
    output logic        last
);

    logic [16:0] beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            beats <= '0;
        end else if (load) begin
            addr  <= load_addr;
            beats <= load_beats;
        end else if (step) begin
            addr  <= addr + 64'(BEAT_BYTES);
            beats <= beats - 17'd1;
        end
    end

    assign last = (beats == 17'd1);

endmodule

// File: rtl/adma_transfer.sv
// ADMA2 descriptor-chain controller: fetches, decodes and executes descriptors.
module adma_transfer
    import adma_pkg::*;
#(
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        adma_start,
    input  logic [63:0] adma_base,
    input  logic        abort,
    output logic        fetch_start,
    output logic [63:0] fetch_address,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [63:0] descriptor,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        int_pulse,
    output logic        error
);

    state_e      state, state_n;
    logic [63:0] cur_addr, next_addr, desc;
    logic [63:0] data_addr;
    logic        load, step, last;

    logic        d_valid, d_end, d_int;
    act_e        d_act;
    logic [15:0] d_len;
    logic [63:0] d_addr;

    assign d_valid = desc[DESC_VALID_BIT];
    assign d_end   = desc[DESC_END_BIT];
    assign d_int   = desc[DESC_INT_BIT];
    assign d_act   = act_e'(desc[DESC_ACT_LSB +: 2]);
    assign d_len   = desc[DESC_LEN_LSB +: 16];
    assign d_addr  = {32'd0, desc[DESC_ADDR_LSB +: 32]};

    adma_beat_counter #(.BEAT_BYTES(BEAT_BYTES)) u_beats (
        .clk        (CLK),
        .rst_n      (RST_L),
        .load       (load),
        .load_addr  (d_addr),
        .load_beats (beats_for_len(d_len, BEAT_BYTES)),
        .step       (step),
        .addr       (data_addr),
        .last       (last)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) state <= S_IDLE;
        else        state <= state_n;
    end

    // Abort overrides everything, so all strobes stay low in that cycle.
    always_comb begin
        state_n     = state;
        fetch_start = 1'b0;
        desc_ready  = 1'b0;
        mem_req     = 1'b0;
        int_pulse   = 1'b0;
        done        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (adma_start) state_n = S_FETCH;
                S_FETCH: begin
                    fetch_start = 1'b1;
                    state_n     = S_WAIT_DESC;
                end
                S_WAIT_DESC: begin
                    desc_ready = 1'b1;
                    if (desc_valid) state_n = S_DECODE;
                end
                S_DECODE: begin
                    if (!d_valid) begin
                        state_n = S_ERR;
                    end else if (d_act == ACT_TRAN) begin
                        load    = 1'b1;
                        state_n = S_XFER;
                    end else begin
                        state_n = S_NEXT;
                    end
                end
                S_XFER: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        step = 1'b1;
                        if (last) state_n = S_NEXT;
                    end
                end
                S_NEXT: begin
                    int_pulse = d_int;
                    state_n   = d_end ? S_FINISH : S_FETCH;
                end
                S_FINISH: begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
                S_ERR:       state_n = S_IDLE;
                default:     state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            cur_addr  <= '0;
            next_addr <= '0;
            desc      <= '0;
            error     <= 1'b0;
        end else if (!abort) begin
            if (state == S_IDLE && adma_start) begin
                cur_addr <= adma_base;
                error    <= 1'b0;
            end
            if (state == S_WAIT_DESC && desc_valid) desc <= descriptor;
            if (state == S_DECODE)
                next_addr <= (d_act == ACT_LINK) ? d_addr : cur_addr + DESC_STRIDE;
            if (state == S_NEXT && !d_end) cur_addr <= next_addr;
            if (state == S_ERR) error <= 1'b1;
        end
    end

    assign busy          = (state != S_IDLE);
    assign fetch_address = fetch_start ? cur_addr : '0;
    assign mem_addr      = mem_req ? data_addr : '0;

endmodule

// File: tb/tb_adma_transfer.sv
// Scoreboard bench for adma_transfer: descriptor memory model plus randomised beat acks.
module tb_adma_transfer;

    localparam int unsigned BB = 4;

    logic        CLK = 1'b0;
    logic        RST_L;
    logic        adma_start, abort, desc_valid, mem_ack;
    logic [63:0] adma_base, descriptor;
    logic        fetch_start, desc_ready, mem_req, busy, done, int_pulse, error;
    logic [63:0] fetch_address, mem_addr;

    adma_transfer #(.BEAT_BYTES(BB)) dut (
        .CLK           (CLK),
        .RST_L         (RST_L),
        .adma_start    (adma_start),
        .adma_base     (adma_base),
        .abort         (abort),
        .fetch_start   (fetch_start),
        .fetch_address (fetch_address),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .descriptor    (descriptor),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .busy          (busy),
        .done          (done),
        .int_pulse     (int_pulse),
        .error         (error)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0, n_fail = 0;
    logic [63:0] exp_fetch[$];
    logic [63:0] exp_mem[$];
    logic [63:0] dt_addr[$];
    logic [63:0] dt_word[$];
    bit          auto_desc = 1'b1, auto_ack = 1'b1, pend = 1'b0;
    logic [63:0] pend_desc, last_mem;
    int unsigned cyc = 0, n_done = 0, n_int = 0, done_cyc = 0, int_cyc = 0;
    int unsigned n_memreq = 0, n_beats = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkdesc(input logic [31:0] a, input logic [15:0] len,
                                           input logic [1:0] act, input bit irq,
                                           input bit e, input bit valid, input bit junk);
        return {a, len, (junk ? 10'h3FF : 10'h000), act, junk, irq, e, valid};
    endfunction

    function automatic logic [63:0] desc_at(input logic [63:0] addr);
        foreach (dt_addr[i]) if (dt_addr[i] == addr) return dt_word[i];
        return '0;
    endfunction

    // One cycle: observe DUT at the falling edge, then drive the responders.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (int_pulse) begin n_int++; int_cyc = cyc; end
        if (mem_req) n_memreq++;
        if (fetch_start) begin
            if (exp_fetch.size() > 0) check("fetch_addr", fetch_address, exp_fetch.pop_front());
            else check("fetch_unexpected", {63'd0, fetch_start}, 64'd0);
            pend_desc = desc_at(fetch_address);
            pend = 1'b1;
        end
        if (auto_desc) begin
            desc_valid = 1'b0;
            if (pend && desc_ready && $urandom_range(0, 1) == 1) begin
                desc_valid = 1'b1;
                descriptor = pend_desc;
                pend = 1'b0;
            end
        end
        if (auto_ack) begin
            mem_ack = 1'b0;
            if (mem_req && $urandom_range(0, 3) != 0) begin
                mem_ack = 1'b1;
                n_beats++;
                last_mem = mem_addr;
                if (exp_mem.size() > 0) check("mem_addr", mem_addr, exp_mem.pop_front());
                else check("mem_unexpected", {63'd0, mem_req}, 64'd0);
            end
        end
    endtask

    task automatic clear_tb();
        exp_fetch.delete(); exp_mem.delete(); dt_addr.delete(); dt_word.delete();
        n_done = 0; n_int = 0; n_memreq = 0; n_beats = 0; pend = 1'b0;
        done_cyc = 0; int_cyc = 0;
        auto_desc = 1'b1; auto_ack = 1'b1;
        desc_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic put_desc(input logic [63:0] a, input logic [63:0] w);
        dt_addr.push_back(a);
        dt_word.push_back(w);
    endtask

    task automatic start(input logic [63:0] base);
        adma_base = base;
        adma_start = 1'b1;
        tick();
        adma_start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned i = 0;
        while (busy && i < budget) begin tick(); i++; end
        if (busy) check("timeout_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_mem_req(input int unsigned budget);
        int unsigned i = 0;
        while (!mem_req && i < budget) begin tick(); i++; end
        if (!mem_req) check("timeout_mem_req", {63'd0, mem_req}, 64'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_fetch_left"}, 64'(exp_fetch.size()), 64'd0);
        check({tag, "_mem_left"}, 64'(exp_mem.size()), 64'd0);
    endtask

    initial begin
        RST_L = 1'b0; adma_start = 1'b0; abort = 1'b0; desc_valid = 1'b0;
        mem_ack = 1'b0; adma_base = '0; descriptor = '0;
        #1;
        check("rst_outputs", {busy, done, int_pulse, error, fetch_start, desc_ready, mem_req}, 64'd0);
        check("rst_fetch_address", fetch_address, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        tick(); tick();
        RST_L = 1'b1;
        tick();

        // Single tran descriptor with int and end.
        clear_tb();
        put_desc(64'h40, mkdesc(32'h1000, 16'd8, 2'b10, 1, 1, 1, 0));
        exp_fetch.push_back(64'h40);
        exp_mem.push_back(64'h1000); exp_mem.push_back(64'h1004);
        start(64'h40);
        wait_idle(200);
        check("t1_done", 64'(n_done), 64'd1);
        check("t1_int", 64'(n_int), 64'd1);
        check("t1_done_after_int", 64'(done_cyc - int_cyc), 64'd1);
        check("t1_error", {63'd0, error}, 64'd0);
        check_drained("t1");

        // tran -> link -> nop/end chain, ignored descriptor bits set.
        clear_tb();
        put_desc(64'h40, mkdesc(32'h2000, 16'd4, 2'b10, 0, 0, 1, 1));
        put_desc(64'h48, mkdesc(32'h300, 16'd0, 2'b11, 0, 0, 1, 1));
        put_desc(64'h300, mkdesc(32'h0, 16'd0, 2'b00, 0, 1, 1, 1));
        exp_fetch.push_back(64'h40); exp_fetch.push_back(64'h48); exp_fetch.push_back(64'h300);
        exp_mem.push_back(64'h2000);
        start(64'h40);
        wait_idle(300);
        check("t2_done", 64'(n_done), 64'd1);
        check("t2_int", 64'(n_int), 64'd0);
        check_drained("t2");

        // Invalid descriptor -> sticky error.
        clear_tb();
        put_desc(64'h80, mkdesc(32'h5000, 16'd8, 2'b10, 1, 1, 0, 0));
        exp_fetch.push_back(64'h80);
        start(64'h80);
        wait_idle(200);
        repeat (5) tick();
        check("t3_error", {63'd0, error}, 64'd1);
        check("t3_busy", {63'd0, busy}, 64'd0);
        check("t3_done", 64'(n_done), 64'd0);
        check("t3_memreq", 64'(n_memreq), 64'd0);
        check_drained("t3");

        // Fresh start clears the error flag.
        clear_tb();
        put_desc(64'h40, mkdesc(32'h1000, 16'd8, 2'b10, 1, 1, 1, 0));
        exp_fetch.push_back(64'h40);
        exp_mem.push_back(64'h1000); exp_mem.push_back(64'h1004);
        start(64'h40);
        check("t4_error_cleared", {63'd0, error}, 64'd0);
        wait_idle(200);
        check("t4_done", 64'(n_done), 64'd1);
        check_drained("t4");

        // 64-bit wrap of cur_addr+8.
        clear_tb();
        put_desc(64'hFFFF_FFFF_FFFF_FFF8, mkdesc(32'h0, 16'd0, 2'b01, 0, 0, 1, 0));
        put_desc(64'h0, mkdesc(32'h0, 16'd0, 2'b00, 1, 1, 1, 0));
        exp_fetch.push_back(64'hFFFF_FFFF_FFFF_FFF8); exp_fetch.push_back(64'h0);
        start(64'hFFFF_FFFF_FFFF_FFF8);
        wait_idle(200);
        check("t5_done", 64'(n_done), 64'd1);
        check("t5_int", 64'(n_int), 64'd1);
        check("t5_error", {63'd0, error}, 64'd0);
        check_drained("t5");

        // Zero length means 64 KiB.
        clear_tb();
        put_desc(64'h100, mkdesc(32'h8000_0000, 16'd0, 2'b10, 0, 1, 1, 1));
        exp_fetch.push_back(64'h100);
        for (int unsigned i = 0; i < 16384; i++) exp_mem.push_back(64'h8000_0000 + 64'(i * 4));
        start(64'h100);
        wait_idle(40000);
        check("t6_beats", 64'(n_beats), 64'd16384);
        check("t6_last_addr", last_mem, 64'h8000_FFFC);
        check("t6_done", 64'(n_done), 64'd1);
        check_drained("t6");

        // Abort together with the second beat's ack.
        clear_tb();
        auto_ack = 1'b0;
        put_desc(64'h200, mkdesc(32'h3000, 16'd16, 2'b10, 1, 1, 1, 0));
        exp_fetch.push_back(64'h200);
        start(64'h200);
        wait_mem_req(50);
        check("t7_beat0_addr", mem_addr, 64'h3000);
        mem_ack = 1'b1;
        tick();
        check("t7_beat1_addr", mem_addr, 64'h3004);
        abort = 1'b1;
        tick();
        abort = 1'b0; mem_ack = 1'b0;
        check("t7_idle", {62'd0, busy, mem_req}, 64'd0);
        repeat (4) tick();
        check("t7_no_done", 64'(n_done), 64'd0);
        check("t7_no_int", 64'(n_int), 64'd0);
        check_drained("t7");

        // Reset in the middle of a data phase.
        clear_tb();
        auto_ack = 1'b0;
        put_desc(64'h200, mkdesc(32'h3000, 16'd16, 2'b10, 1, 1, 1, 0));
        exp_fetch.push_back(64'h200);
        start(64'h200);
        wait_mem_req(50);
        RST_L = 1'b0;
        #1;
        check("t8_rst_flags", {busy, done, int_pulse, error, fetch_start, desc_ready, mem_req}, 64'd0);
        check("t8_rst_mem_addr", mem_addr, 64'd0);
        check("t8_rst_fetch_address", fetch_address, 64'd0);
        tick();
        RST_L = 1'b1;
        pend = 1'b0;
        repeat (5) tick();
        check("t8_stays_idle", {63'd0, busy}, 64'd0);
        check("t8_no_done", 64'(n_done), 64'd0);

        // adma_start while busy is ignored.
        clear_tb();
        auto_ack = 1'b0;
        put_desc(64'h40, mkdesc(32'h1000, 16'd8, 2'b10, 1, 1, 1, 0));
        put_desc(64'h999, mkdesc(32'h7000, 16'd4, 2'b10, 0, 1, 1, 0));
        exp_fetch.push_back(64'h40);
        exp_mem.push_back(64'h1000); exp_mem.push_back(64'h1004);
        start(64'h40);
        wait_mem_req(50);
        start(64'h999);
        check("t9_busy_start_addr", mem_addr, 64'h1000);
        auto_ack = 1'b1;
        wait_idle(200);
        check("t9_done", 64'(n_done), 64'd1);
        check_drained("t9");

        // Spurious handshakes in IDLE.
        clear_tb();
        auto_desc = 1'b0; auto_ack = 1'b0;
        mem_ack = 1'b1; desc_valid = 1'b1; descriptor = mkdesc(32'h1, 16'd4, 2'b10, 1, 1, 1, 0);
        repeat (4) begin
            tick();
            check("t10_spurious", {busy, done, int_pulse, error, fetch_start, desc_ready, mem_req}, 64'd0);
        end
        mem_ack = 1'b0; desc_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
